// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - round-robin arbiter sharing one single-beat AXI4 master between fetch and load/store
module core_mem_arbiter #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter bit C_INIT_PRIO        = 1'b1
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,

    input  logic                              I_REQ,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     I_ADDR,
    output logic                              I_ACK,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     I_RDATA,
    output logic                              I_ERR,

    input  logic                              D_REQ,
    input  logic                              D_WE,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     D_ADDR,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     D_WDATA,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   D_STRB,
    output logic                              D_ACK,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     D_RDATA,
    output logic                              D_ERR,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WLAST,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RLAST,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_R,
        S_WR_AW,
        S_WR_B,
        S_DONE
    } state_t;

    state_t state;
    logic   prio_d;     // 1: data side wins the next simultaneous request
    logic   owner_d;    // 1: current transaction belongs to the data side
    logic   grant_d;
    logic   aw_done;
    logic   w_done;
    logic   unused_inputs;

    assign grant_d       = D_REQ && (!I_REQ || prio_d);
    assign aw_done       = !M_AXI_AWVALID || M_AXI_AWREADY;
    assign w_done        = !M_AXI_WVALID || M_AXI_WREADY;
    assign M_AXI_WLAST   = M_AXI_WVALID;
    assign unused_inputs = ^{M_AXI_RLAST, I_ADDR[1:0], D_ADDR[1:0]};

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state         <= S_IDLE;
            prio_d        <= C_INIT_PRIO;
            owner_d       <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            I_ACK         <= 1'b0;
            I_RDATA       <= '0;
            I_ERR         <= 1'b0;
            D_ACK         <= 1'b0;
            D_RDATA       <= '0;
            D_ERR         <= 1'b0;
        end else begin
            I_ACK <= 1'b0;
            D_ACK <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (I_REQ || D_REQ) begin
                        owner_d <= grant_d;
                        prio_d  <= !grant_d;
                        if (grant_d && D_WE) begin
                            M_AXI_AWADDR  <= {D_ADDR[AW-1:2], 2'b00};
                            M_AXI_WDATA   <= D_WDATA;
                            M_AXI_WSTRB   <= D_STRB;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state         <= S_WR_AW;
                        end else begin
                            M_AXI_ARADDR  <= grant_d ? {D_ADDR[AW-1:2], 2'b00}
                                                     : {I_ADDR[AW-1:2], 2'b00};
                            M_AXI_ARVALID <= 1'b1;
                            state         <= S_RD_A;
                        end
                    end
                end
                S_RD_A: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= S_RD_R;
                    end
                end
                S_RD_R: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        if (owner_d) begin
                            D_RDATA <= M_AXI_RDATA;
                            D_ERR   <= (M_AXI_RRESP != 2'b00);
                            D_ACK   <= 1'b1;
                        end else begin
                            I_RDATA <= M_AXI_RDATA;
                            I_ERR   <= (M_AXI_RRESP != 2'b00);
                            I_ACK   <= 1'b1;
                        end
                        state <= S_DONE;
                    end
                end
                S_WR_AW: begin
                    // AW and W complete independently; move on once both have handshaken
                    if (M_AXI_AWREADY) begin
                        M_AXI_AWVALID <= 1'b0;
                    end
                    if (M_AXI_WREADY) begin
                        M_AXI_WVALID <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= S_WR_B;
                    end
                end
                S_WR_B: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        D_ERR        <= (M_AXI_BRESP != 2'b00);
                        D_ACK        <= 1'b1;
                        state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb/tb_core_mem_arbiter.sv - self-checking bench for core_mem_arbiter with an AXI slave model
module tb_core_mem_arbiter;
    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        I_REQ = 1'b0;
    logic [31:0] I_ADDR = '0;
    logic        I_ACK;
    logic [31:0] I_RDATA;
    logic        I_ERR;
    logic        D_REQ = 1'b0;
    logic        D_WE = 1'b0;
    logic [31:0] D_ADDR = '0;
    logic [31:0] D_WDATA = '0;
    logic [3:0]  D_STRB = '0;
    logic        D_ACK;
    logic [31:0] D_RDATA;
    logic        D_ERR;
    logic [31:0] M_AXI_AWADDR;
    logic        M_AXI_AWVALID, M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY;
    logic [31:0] M_AXI_ARADDR;
    logic        M_AXI_ARVALID, M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;

    core_mem_arbiter dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_ACK(I_ACK), .I_RDATA(I_RDATA), .I_ERR(I_ERR),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_STRB(D_STRB),
        .D_ACK(D_ACK), .D_RDATA(D_RDATA), .D_ERR(D_ERR),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction
    function automatic logic [1:0] resp_of(input logic [31:0] a);
        return (a[6:4] == 3'b101) ? 2'b10 : 2'b00;
    endfunction

    // Slave: fixed table-driven behaviour when use_cfg=1, random waits and address-derived data otherwise
    logic        use_cfg = 1'b1;
    logic [31:0] cfg_rdata = '0;
    logic [1:0]  cfg_resp = '0;
    int cfg_a_wait = 0, cfg_w_wait = 0, cfg_r_wait = 0;
    int rnd_ar = 0, rnd_r = 0, rnd_aw = 0, rnd_w = 0, rnd_b = 0;
    int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    int ar_w, r_w, aw_w, w_w, b_w;
    logic r_pend = 1'b0, b_pend = 1'b0, aw_got = 1'b0, w_got = 1'b0, ar_stall = 1'b0;
    logic [31:0] stall_addr = '0, r_addr = '0, last_araddr = '0, last_awaddr = '0, last_wdata = '0;
    logic [3:0]  last_wstrb = '0;
    int arvalid_cycles = 0, awvalid_cycles = 0, wvalid_cycles = 0, b_beats = 0, viol = 0;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

    assign ar_w = use_cfg ? cfg_a_wait : rnd_ar;
    assign aw_w = use_cfg ? cfg_a_wait : rnd_aw;
    assign w_w  = use_cfg ? cfg_w_wait : rnd_w;
    assign r_w  = use_cfg ? cfg_r_wait : rnd_r;
    assign b_w  = use_cfg ? cfg_r_wait : rnd_b;
    assign M_AXI_ARREADY = M_AXI_ARVALID && (ar_cnt >= ar_w);
    assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_w);
    assign M_AXI_WREADY  = M_AXI_WVALID && (w_cnt >= w_w);
    assign M_AXI_RVALID  = r_pend && (r_cnt >= r_w);
    assign M_AXI_BVALID  = b_pend && (b_cnt >= b_w);
    assign M_AXI_RDATA   = use_cfg ? cfg_rdata : word_of(r_addr);
    assign M_AXI_RRESP   = use_cfg ? cfg_resp : resp_of(r_addr);
    assign M_AXI_BRESP   = use_cfg ? cfg_resp : resp_of(last_awaddr);
    assign M_AXI_RLAST   = M_AXI_RVALID;
    assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
    assign r_hs  = M_AXI_RVALID && M_AXI_RREADY;
    assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
    assign b_hs  = M_AXI_BVALID && M_AXI_BREADY;

    always @(posedge ACLK) begin
        if (!ARESETN) begin
            ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
            r_pend <= 1'b0; b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; ar_stall <= 1'b0;
        end else begin
            viol <= viol + int'(ar_stall && (!M_AXI_ARVALID || M_AXI_ARADDR != stall_addr))
                         + int'(I_ACK && D_ACK) + int'(M_AXI_WLAST != M_AXI_WVALID)
                         + int'((M_AXI_ARVALID || M_AXI_AWVALID) && (r_pend || b_pend));
            arvalid_cycles <= arvalid_cycles + int'(M_AXI_ARVALID);
            awvalid_cycles <= awvalid_cycles + int'(M_AXI_AWVALID);
            wvalid_cycles  <= wvalid_cycles + int'(M_AXI_WVALID);
            ar_stall   <= M_AXI_ARVALID && !M_AXI_ARREADY;
            stall_addr <= M_AXI_ARADDR;
            if (ar_hs) begin
                ar_cnt <= 0; r_pend <= 1'b1; r_cnt <= 0;
                r_addr <= M_AXI_ARADDR; last_araddr <= M_AXI_ARADDR;
                rnd_ar <= $urandom_range(0, 3);
            end else if (M_AXI_ARVALID) ar_cnt <= ar_cnt + 1;
            if (r_hs) begin
                r_pend <= 1'b0; rnd_r <= $urandom_range(0, 3);
            end else if (r_pend) r_cnt <= r_cnt + 1;
            if (aw_hs) begin
                aw_cnt <= 0; aw_got <= 1'b1; last_awaddr <= M_AXI_AWADDR;
                rnd_aw <= $urandom_range(0, 3);
            end else if (M_AXI_AWVALID) aw_cnt <= aw_cnt + 1;
            if (w_hs) begin
                w_cnt <= 0; w_got <= 1'b1; last_wdata <= M_AXI_WDATA; last_wstrb <= M_AXI_WSTRB;
                rnd_w <= $urandom_range(0, 3);
            end else if (M_AXI_WVALID) w_cnt <= w_cnt + 1;
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1; b_cnt <= 0;
            end
            if (b_hs) begin
                b_pend <= 1'b0; b_beats <= b_beats + 1; rnd_b <= $urandom_range(0, 3);
            end else if (b_pend) b_cnt <= b_cnt + 1;
        end
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic do_txn(input bit side, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb, output int lat);
        @(negedge ACLK);
        if (side) begin
            D_WE = we; D_ADDR = addr; D_WDATA = wdata; D_STRB = strb; D_REQ = 1'b1;
        end else begin
            I_ADDR = addr; I_REQ = 1'b1;
        end
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge ACLK);
            if ((side && D_ACK) || (!side && I_ACK)) begin
                lat = c;
                break;
            end
        end
        I_REQ = 1'b0;
        D_REQ = 1'b0;
    endtask

    task automatic run_i(input int n);
        logic [31:0] a;
        bit got;
        int gap;
        for (int k = 0; k < n; k++) begin
            a = $urandom;
            I_ADDR = a; I_REQ = 1'b1;
            got = 1'b0;
            for (int t = 0; t < 300; t++) begin
                @(negedge ACLK);
                if (I_ACK) begin got = 1'b1; break; end
            end
            if (!got) begin
                check("rand_i_timeout", 32'(got), 32'd1);
                break;
            end
            check("rand_i_araddr", last_araddr, a & 32'hFFFF_FFFC);
            check("rand_i_rdata", I_RDATA, word_of(a & 32'hFFFF_FFFC));
            check("rand_i_err", 32'(I_ERR), 32'(resp_of(a & 32'hFFFF_FFFC) != 2'b00));
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                I_REQ = 1'b0;
                repeat (gap) @(negedge ACLK);
            end
        end
        I_REQ = 1'b0;
    endtask

    task automatic run_d(input int n, input logic [31:0] d_init);
        logic [31:0] a, wd, d_last;
        logic [3:0]  st;
        bit we, got;
        int gap;
        d_last = d_init;
        for (int k = 0; k < n; k++) begin
            a = $urandom; wd = $urandom; st = 4'($urandom_range(0, 15)); we = 1'($urandom_range(0, 1));
            D_ADDR = a; D_WDATA = wd; D_STRB = st; D_WE = we; D_REQ = 1'b1;
            got = 1'b0;
            for (int t = 0; t < 300; t++) begin
                @(negedge ACLK);
                if (D_ACK) begin got = 1'b1; break; end
            end
            if (!got) begin
                check("rand_d_timeout", 32'(got), 32'd1);
                break;
            end
            if (we) begin
                check("rand_d_awaddr", last_awaddr, a & 32'hFFFF_FFFC);
                check("rand_d_wdata", last_wdata, wd);
                check("rand_d_wstrb", 32'(last_wstrb), 32'(st));
                check("rand_d_rdata_held", D_RDATA, d_last);
            end else begin
                check("rand_d_araddr", last_araddr, a & 32'hFFFF_FFFC);
                d_last = word_of(a & 32'hFFFF_FFFC);
                check("rand_d_rdata", D_RDATA, d_last);
            end
            check("rand_d_err", 32'(D_ERR), 32'(resp_of(a & 32'hFFFF_FFFC) != 2'b00));
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                D_REQ = 1'b0;
                repeat (gap) @(negedge ACLK);
            end
        end
        D_REQ = 1'b0;
    endtask

    typedef struct {
        bit          side;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] s_rdata;
        logic [1:0]  s_resp;
        int          a_wait;
        int          w_wait;
        int          r_wait;
        logic [31:0] exp_axaddr;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
        int          exp_avalid;
    } vec_t;

    vec_t vecs[8];
    vec_t v;
    int lat, av0, wv0, b0, nack;
    bit seen;
    logic order[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h104,  32'h0,        4'b0000, 32'hDEADBEEF, 2'b00, 0,  0, 0, 32'h104,  32'hDEADBEEF, 1'b0, 3,  1};
        vecs[1] = '{1'b1, 1'b1, 32'h200,  32'h12345678, 4'b0011, 32'h0,        2'b00, 2,  0, 0, 32'h200,  32'hDEADBEEF, 1'b0, 5,  3};
        vecs[2] = '{1'b0, 1'b0, 32'h1002, 32'h0,        4'b0000, 32'hCAFEF00D, 2'b10, 0,  0, 0, 32'h1000, 32'hCAFEF00D, 1'b1, 3,  1};
        vecs[3] = '{1'b0, 1'b0, 32'h2000, 32'h0,        4'b0000, 32'h0BADF00D, 2'b00, 0,  0, 0, 32'h2000, 32'h0BADF00D, 1'b0, 3,  1};
        vecs[4] = '{1'b0, 1'b0, 32'h3000, 32'h0,        4'b0000, 32'h11112222, 2'b00, 20, 0, 0, 32'h3000, 32'h11112222, 1'b0, 23, 21};
        vecs[5] = '{1'b1, 1'b1, 32'h7FF3, 32'hA5A5A5A5, 4'b1100, 32'h0,        2'b10, 0,  3, 1, 32'h7FF0, 32'hDEADBEEF, 1'b1, 7,  1};
        vecs[6] = '{1'b1, 1'b0, 32'h41,   32'h0,        4'b0000, 32'h55AA55AA, 2'b11, 0,  0, 2, 32'h40,   32'h55AA55AA, 1'b1, 5,  1};
        vecs[7] = '{1'b1, 1'b0, 32'h44,   32'h0,        4'b0000, 32'h01020304, 2'b00, 0,  0, 0, 32'h44,   32'h01020304, 1'b0, 3,  1};

        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_valids", 32'({M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_RREADY}), 32'd0);
        check("rst_acks_errs", 32'({I_ACK, D_ACK, I_ERR, D_ERR}), 32'd0);
        check("rst_i_rdata", I_RDATA, 32'd0);
        check("rst_d_rdata", D_RDATA, 32'd0);
        ARESETN = 1'b1;

        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            cfg_rdata = v.s_rdata; cfg_resp = v.s_resp;
            cfg_a_wait = v.a_wait; cfg_w_wait = v.w_wait; cfg_r_wait = v.r_wait;
            av0 = v.we ? awvalid_cycles : arvalid_cycles;
            wv0 = wvalid_cycles;
            b0  = b_beats;
            do_txn(v.side, v.we, v.addr, v.wdata, v.strb, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(v.exp_lat));
            check($sformatf("vec%0d_axaddr", i), v.we ? last_awaddr : last_araddr, v.exp_axaddr);
            check($sformatf("vec%0d_rdata", i), v.side ? D_RDATA : I_RDATA, v.exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(v.side ? D_ERR : I_ERR), 32'(v.exp_err));
            @(negedge ACLK);
            check($sformatf("vec%0d_ack_one_cycle", i), 32'({I_ACK, D_ACK}), 32'd0);
            check($sformatf("vec%0d_avalid_cycles", i),
                  32'((v.we ? awvalid_cycles : arvalid_cycles) - av0), 32'(v.exp_avalid));
            if (v.we) begin
                check($sformatf("vec%0d_wdata", i), last_wdata, v.wdata);
                check($sformatf("vec%0d_wstrb", i), 32'(last_wstrb), 32'(v.strb));
                check($sformatf("vec%0d_wvalid_cycles", i), 32'(wvalid_cycles - wv0), 32'(v.w_wait + 1));
                check($sformatf("vec%0d_b_beats", i), 32'(b_beats - b0), 32'd1);
            end
        end

        // Reset while waiting in the read-response phase
        cfg_rdata = 32'h77777777; cfg_resp = 2'b00; cfg_a_wait = 0; cfg_w_wait = 0; cfg_r_wait = 5;
        @(negedge ACLK);
        D_WE = 1'b0; D_ADDR = 32'h80; D_REQ = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge ACLK);
            if (M_AXI_RREADY) begin seen = 1'b1; break; end
        end
        check("rst_mid_reached_rd_r", 32'(seen), 32'd1);
        ARESETN = 1'b0;
        D_REQ = 1'b0;
        @(posedge ACLK);
        #1;
        check("rst_mid_rready", 32'(M_AXI_RREADY), 32'd0);
        check("rst_mid_arvalid", 32'(M_AXI_ARVALID), 32'd0);
        check("rst_mid_ack", 32'({I_ACK, D_ACK}), 32'd0);
        check("rst_mid_d_rdata", D_RDATA, 32'd0);
        @(negedge ACLK);
        ARESETN = 1'b1;

        // Both requesters held high: data wins first after reset, then strict alternation
        cfg_rdata = 32'h600DCAFE; cfg_r_wait = 0;
        @(negedge ACLK);
        I_ADDR = 32'h3000; D_ADDR = 32'h4000; D_WE = 1'b0;
        I_REQ = 1'b1; D_REQ = 1'b1;
        nack = 0;
        for (int c = 0; c < 200 && nack < 6; c++) begin
            @(negedge ACLK);
            if (I_ACK || D_ACK) begin
                order[nack] = D_ACK;
                nack++;
            end
        end
        I_REQ = 1'b0; D_REQ = 1'b0;
        check("fair_ack_count", 32'(nack), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < nack) check($sformatf("fair_order_%0d_is_d", k), 32'(order[k]), 32'((k % 2) == 0));
        end
        repeat (2) @(negedge ACLK);

        // Random concurrent traffic against the address-derived memory model
        use_cfg = 1'b0;
        fork
            run_i(40);
            run_d(40, 32'h600DCAFE);
        join
        repeat (4) @(negedge ACLK);
        check("protocol_violations", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
